// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO and a status register.
// Software polls STATUS for space and idle; DIVCHK lets it confirm the baud divisor.
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          overflow;

    logic full, empty, baud_done, data_wr, push, pop, ovf_set, ovf_clr;
    logic [4:0]  cnt5;
    logic [15:0] status;
    logic [7:0]  unused_wdata_hi;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign data_wr   = wr_en && (addr == 2'd0);
    // Full is judged on the pre-pop count, so a write into a full FIFO drops even if a pop coincides.
    assign push      = data_wr && !full;
    assign ovf_set   = data_wr && full;
    assign ovf_clr   = wr_en && (addr == 2'd1) && wdata[3];
    assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_done));
    assign tx_busy   = !empty || (state != IDLE);
    assign cnt5      = 5'(count);
    assign status    = {7'b0, cnt5, overflow, tx_busy, empty, full};
    assign unused_wdata_hi = wdata[15:8];

    always_comb begin
        rdata = 16'h0000;
        if (rd_en) begin
            case (addr)
                2'd1:    rdata = status;
                2'd2:    rdata = 16'(CLKS_PER_BIT);
                default: rdata = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        overflow <= 1'b0;
        else if (ovf_set) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                    end else begin
                        tx <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        // Back-to-back frames: go straight from stop to the next start bit.
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
